// File: rtl/sched_pkg.sv
// Shared definitions for the task scheduler slice:
// command opcodes, entry field widths, task and scheduler state encodings.
package sched_pkg;

    localparam int ID_W   = 4;
    localparam int PRIO_W = 4;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_EXEC    = 4'b0111;
    localparam logic [3:0] OP_FINISH  = 4'b1111;
    localparam logic [3:0] OP_SETPRIO = 4'b0101;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'b00,
        TS_READY = 2'b01,
        TS_RUN   = 2'b10,
        TS_DONE  = 2'b11
    } task_state_e;

    typedef enum logic [2:0] {
        SCAN,
        DISPATCH,
        WAIT_ON,
        RUN,
        FINISH,
        WAIT_OFF
    } sched_state_e;

    function automatic logic [15:0] mk_cmd(
        input logic [ID_W-1:0] id,
        input logic [3:0]      op,
        input logic [3:0]      arg
    );
        return {4'h0, id, op, arg};
    endfunction

endpackage

// File: rtl/task_scheduler_if.sv
// Sorter/exe_flag inputs and command bus of the task scheduler.
// master = scheduler side, slave = task-block side.
interface task_scheduler_if #(
    parameter int N_TASKS = 8
);
    import sched_pkg::*;

    logic [N_TASKS*8-1:0] task_entry;
    logic [N_TASKS-1:0]   task_exe;
    logic [15:0]          cmd_op;
    logic                 running_valid;
    logic [ID_W-1:0]      running_id;
    logic                 sched_err;

    modport master (
        input  task_entry,
        input  task_exe,
        output cmd_op,
        output running_valid,
        output running_id,
        output sched_err
    );

    modport slave (
        output task_entry,
        output task_exe,
        input  cmd_op,
        input  running_valid,
        input  running_id,
        input  sched_err
    );

endinterface

// File: rtl/sched_pick.sv
// Combinational picker: highest effective priority among Ready slots,
// ties broken round-robin starting just after last_grant.
module sched_pick
    import sched_pkg::*;
#(
    parameter int N_TASKS = 8,
    parameter int IW      = $clog2(N_TASKS)
) (
    input  logic [N_TASKS*8-1:0]      entry,
    input  logic [N_TASKS*PRIO_W-1:0] eff,
    input  logic [IW-1:0]             last_grant,
    output logic                      found,
    output logic [IW-1:0]             idx,
    output logic [ID_W-1:0]           id
);

    logic [PRIO_W-1:0] best;
    logic              hit;

    // Max search first, then the first tied slot after last_grant.
    always_comb begin
        found = 1'b0;
        best  = '0;
        hit   = 1'b0;
        idx   = '0;
        id    = '0;
        for (int i = 0; i < N_TASKS; i++) begin
            if (entry[8*i +: 8] != 8'h00) begin
                if (!found || eff[PRIO_W*i +: PRIO_W] > best)
                    best = eff[PRIO_W*i +: PRIO_W];
                found = 1'b1;
            end
        end
        for (int k = 1; k <= N_TASKS; k++) begin
            int j;
            j = (int'(last_grant) + k) % N_TASKS;
            if (!hit && entry[8*j +: 8] != 8'h00 &&
                eff[PRIO_W*j +: PRIO_W] == best) begin
                hit = 1'b1;
                idx = IW'(j);
                id  = entry[8*j + PRIO_W +: ID_W];
            end
        end
    end

endmodule

// File: rtl/task_scheduler.sv
// Central task scheduler: pick, EXEC, run quantum, FINISH on the cmd bus.
// Optional priority aging is built when SCHED_AGING_EN is defined.
module task_scheduler
    import sched_pkg::*;
#(
    parameter int N_TASKS     = 8,
    parameter int QUANTUM     = 10000,
    parameter int ACK_TIMEOUT = 16,
    parameter int AGE_STEP    = 1024
) (
    input logic              CLK,
    input logic              RST_N,
    task_scheduler_if.master bus
);

    localparam int IW = $clog2(N_TASKS);
    localparam int QW = $clog2(QUANTUM + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    if (N_TASKS < 2 || N_TASKS > 16 || QUANTUM < 1 ||
        ACK_TIMEOUT < 1 || AGE_STEP < 1) begin : g_bad_cfg
        $error("task_scheduler: parameter out of range");
    end

    sched_state_e      state, state_d;
    logic [IW-1:0]     last_grant, last_grant_d;
    logic [IW-1:0]     sel_idx, sel_idx_d;
    logic [ID_W-1:0]   sel_id, sel_id_d;
    logic [AW-1:0]     ack_cnt, ack_cnt_d;
    logic [QW-1:0]     q_cnt, q_cnt_d;
    logic [15:0]       cmd_q, cmd_d;
    logic              rv_q, rv_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic              err_q, err_d;

    logic [N_TASKS*PRIO_W-1:0] eff;
    logic                      pick_found;
    logic [IW-1:0]             pick_idx;
    logic [ID_W-1:0]           pick_id;

    logic [7:0] sel_entry;
    logic       sel_exe;

    assign sel_entry = bus.task_entry[8*sel_idx +: 8];
    assign sel_exe   = bus.task_exe[sel_idx];

`ifdef SCHED_AGING_EN
    localparam int TW = (AGE_STEP > 1) ? $clog2(AGE_STEP) : 1;

    logic [3:0]        age [N_TASKS];
    logic [TW-1:0]     wt  [N_TASKS];
    logic              setp_q, setp_d;
    logic [PRIO_W-1:0] sel_eff, sel_eff_d;

    // Waiting Ready slots gain one age step per AGE_STEP cycles.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_TASKS; i++) begin
            if (!RST_N || bus.task_entry[8*i +: 8] == 8'h00 ||
                (state == DISPATCH && sel_idx == IW'(i))) begin
                age[i] <= '0;
                wt[i]  <= '0;
            end else if (state == SCAN || sel_idx != IW'(i)) begin
                if (wt[i] == TW'(AGE_STEP - 1)) begin
                    wt[i] <= '0;
                    if (age[i] != 4'hF)
                        age[i] <= age[i] + 4'h1;
                end else begin
                    wt[i] <= wt[i] + TW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_TASKS; g++) begin : g_eff
        logic [4:0] sum;
        assign sum = {1'b0, bus.task_entry[8*g +: PRIO_W]} + {1'b0, age[g]};
        assign eff[PRIO_W*g +: PRIO_W] = sum[4] ? 4'hF : sum[3:0];
    end

    // Pending SETPRIO and the boosted priority it will carry.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            setp_q  <= 1'b0;
            sel_eff <= '0;
        end else begin
            setp_q  <= setp_d;
            sel_eff <= sel_eff_d;
        end
    end
`else
    for (genvar g = 0; g < N_TASKS; g++) begin : g_eff
        assign eff[PRIO_W*g +: PRIO_W] = bus.task_entry[8*g +: PRIO_W];
    end
`endif

    sched_pick #(
        .N_TASKS (N_TASKS),
        .IW      (IW)
    ) u_pick (
        .entry      (bus.task_entry),
        .eff        (eff),
        .last_grant (last_grant),
        .found      (pick_found),
        .idx        (pick_idx),
        .id         (pick_id)
    );

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= SCAN;
            last_grant <= IW'(N_TASKS - 1);
            sel_idx    <= '0;
            sel_id     <= '0;
            ack_cnt    <= '0;
            q_cnt      <= '0;
            cmd_q      <= '0;
            rv_q       <= 1'b0;
            rid_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            sel_idx    <= sel_idx_d;
            sel_id     <= sel_id_d;
            ack_cnt    <= ack_cnt_d;
            q_cnt      <= q_cnt_d;
            cmd_q      <= cmd_d;
            rv_q       <= rv_d;
            rid_q      <= rid_d;
            err_q      <= err_d;
        end
    end

    // Next state, counters and the one-cycle command pulses.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        sel_idx_d    = sel_idx;
        sel_id_d     = sel_id;
        ack_cnt_d    = ack_cnt;
        q_cnt_d      = q_cnt;
        cmd_d        = 16'h0000;
        rv_d         = rv_q;
        rid_d        = rid_q;
        err_d        = err_q;
`ifdef SCHED_AGING_EN
        setp_d       = setp_q;
        sel_eff_d    = sel_eff;
`endif
        unique case (state)
            SCAN: begin
                if (pick_found) begin
                    sel_idx_d = pick_idx;
                    sel_id_d  = pick_id;
`ifdef SCHED_AGING_EN
                    sel_eff_d = eff[PRIO_W*pick_idx +: PRIO_W];
`endif
                    state_d   = DISPATCH;
                end
            end
            DISPATCH: begin
                cmd_d        = mk_cmd(sel_id, OP_EXEC, 4'h0);
                last_grant_d = sel_idx;
                ack_cnt_d    = '0;
`ifdef SCHED_AGING_EN
                setp_d       = 1'b1;
`endif
                state_d      = WAIT_ON;
            end
            WAIT_ON: begin
`ifdef SCHED_AGING_EN
                if (setp_q) begin
                    cmd_d  = mk_cmd(sel_id, OP_SETPRIO, sel_eff);
                    setp_d = 1'b0;
                end
`endif
                if (sel_exe) begin
                    rv_d    = 1'b1;
                    rid_d   = sel_id;
                    q_cnt_d = '0;
                    state_d = RUN;
                end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = SCAN;
                end else begin
                    ack_cnt_d = ack_cnt + AW'(1);
                end
            end
            RUN: begin
                q_cnt_d = q_cnt + QW'(1);
                if (q_cnt == QW'(QUANTUM - 1) || sel_entry == 8'h00 || !sel_exe)
                    state_d = FINISH;
            end
            FINISH: begin
                cmd_d     = mk_cmd(sel_id, OP_FINISH, 4'h0);
                rv_d      = 1'b0;
                rid_d     = '0;
                ack_cnt_d = '0;
                state_d   = WAIT_OFF;
            end
            WAIT_OFF: begin
                if (!sel_exe) begin
                    state_d = SCAN;
                end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = SCAN;
                end else begin
                    ack_cnt_d = ack_cnt + AW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign bus.cmd_op        = cmd_q;
    assign bus.running_valid = rv_q;
    assign bus.running_id    = rid_q;
    assign bus.sched_err     = err_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Directed bench for task_scheduler (default build, short quantum).
// Expected values are hand-derived command words and cycle counts.
module tb_task_scheduler;

    localparam int N  = 8;
    localparam int Q  = 20;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;
    int   bad;

    task_scheduler_if #(.N_TASKS(N)) bus ();

    task_scheduler #(
        .N_TASKS     (N),
        .QUANTUM     (Q),
        .ACK_TIMEOUT (TO),
        .AGE_STEP    (4)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input int k, input logic [7:0] v);
        bus.task_entry[8*k +: 8] = v;
    endtask

    task automatic wait_cmd(output int cnt, input int budget);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.cmd_op == 16'h0000 && cnt < budget);
    endtask

    int          rr_slot [4] = '{0, 3, 6, 0};
    logic [3:0]  rr_id   [4] = '{4'hA, 4'hB, 4'hC, 4'hA};

    initial begin
        bus.task_entry = '0;
        bus.task_exe   = '0;
        tick(); tick(); tick();
        chk("rst_cmd", bus.cmd_op, 16'h0000);
        chk("rst_rv",  16'(bus.running_valid), 16'h0);
        chk("rst_rid", 16'(bus.running_id), 16'h0);
        chk("rst_err", 16'(bus.sched_err), 16'h0);

        // single Ready task, full quantum
        set_entry(2, 8'h53);
        rst_n = 1'b1;
        wait_cmd(n, 8);
        chk("t1_exec", bus.cmd_op, 16'h0570);
        chk("t1_lat", 16'(n), 16'd2);
        bus.task_exe[2] = 1'b1;
        tick();
        chk("t1_pulse", bus.cmd_op, 16'h0000);
        chk("t1_rv", 16'(bus.running_valid), 16'h1);
        chk("t1_rid", 16'(bus.running_id), 16'h5);
        wait_cmd(n, 2*Q);
        chk("t1_fin", bus.cmd_op, 16'h05F0);
        chk("t1_qlen", 16'(n), 16'(Q+1));
        chk("t1_rv_off", 16'(bus.running_valid), 16'h0);
        set_entry(2, 8'h00);
        bus.task_exe[2] = 1'b0;
        tick();
        tick();
        chk("t1_idle", bus.cmd_op, 16'h0000);

        // priority: slot4 (9) before slot1 (3); entry drop; exe fall
        set_entry(1, 8'h13);
        set_entry(4, 8'h49);
        wait_cmd(n, 8);
        chk("t2_exec4", bus.cmd_op, 16'h0470);
        bus.task_exe[4] = 1'b1;
        tick();
        chk("t2_rid4", 16'(bus.running_id), 16'h4);
        tick(); tick(); tick();
        set_entry(4, 8'h00);
        tick();
        chk("t2_drop_q", bus.cmd_op, 16'h0000);
        tick();
        chk("t2_fin4", bus.cmd_op, 16'h04F0);
        bus.task_exe[4] = 1'b0;
        tick();
        wait_cmd(n, 8);
        chk("t2_exec1", bus.cmd_op, 16'h0170);
        chk("t2_lat1", 16'(n), 16'd2);
        bus.task_exe[1] = 1'b1;
        tick();
        chk("t2_rid1", 16'(bus.running_id), 16'h1);
        tick(); tick();
        bus.task_exe[1] = 1'b0;
        tick();
        chk("t2_fall_q", bus.cmd_op, 16'h0000);
        tick();
        chk("t2_fin1", bus.cmd_op, 16'h01F0);
        set_entry(1, 8'h00);
        tick();

        // ack timeout
        set_entry(5, 8'h9F);
        wait_cmd(n, 8);
        chk("to_exec", bus.cmd_op, 16'h0970);
        bad = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (bus.cmd_op != 16'h0000 || bus.sched_err != 1'b0)
                bad++;
        end
        chk("to_quiet", 16'(bad), 16'h0);
        set_entry(5, 8'h00);
        tick();
        chk("to_err", 16'(bus.sched_err), 16'h1);
        chk("to_cmd", bus.cmd_op, 16'h0000);
        tick(); tick();
        chk("to_sticky", 16'(bus.sched_err), 16'h1);
        chk("to_idle", bus.cmd_op, 16'h0000);

        // reset during RUN
        set_entry(3, 8'h32);
        wait_cmd(n, 8);
        chk("rr_exec", bus.cmd_op, 16'h0370);
        bus.task_exe[3] = 1'b1;
        tick();
        chk("rr_rv", 16'(bus.running_valid), 16'h1);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rr_cmd", bus.cmd_op, 16'h0000);
        chk("rr_rv0", 16'(bus.running_valid), 16'h0);
        chk("rr_err0", 16'(bus.sched_err), 16'h0);
        set_entry(3, 8'h00);
        bus.task_exe[3] = 1'b0;
        tick();
        chk("rr_nofin", bus.cmd_op, 16'h0000);
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rr_idle", bus.cmd_op, 16'h0000);

        // round-robin among equal priorities, wrapping
        set_entry(0, 8'hA7);
        set_entry(3, 8'hB7);
        set_entry(6, 8'hC7);
        for (int k = 0; k < 4; k++) begin
            wait_cmd(n, 8);
            chk($sformatf("rr%0d_exec", k), bus.cmd_op,
                {4'h0, rr_id[k], 4'h7, 4'h0});
            chk($sformatf("rr%0d_lat", k), 16'(n), 16'd2);
            bus.task_exe[rr_slot[k]] = 1'b1;
            tick();
            chk($sformatf("rr%0d_rid", k), 16'(bus.running_id),
                16'(rr_id[k]));
            wait_cmd(n, 2*Q);
            chk($sformatf("rr%0d_fin", k), bus.cmd_op,
                {4'h0, rr_id[k], 4'hF, 4'h0});
            chk($sformatf("rr%0d_qlen", k), 16'(n), 16'(Q+1));
            bus.task_exe[rr_slot[k]] = 1'b0;
            if (k == 3)
                bus.task_entry = '0;
            tick();
        end
        tick(); tick();
        chk("end_idle", bus.cmd_op, 16'h0000);
        chk("end_rv", 16'(bus.running_valid), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/task_scheduler.md
Name: task_scheduler

Overview:
- Central scheduler for the per-task hardware blocks.
- Each cycle it samples every task's 8-bit sorter entry (task id and priority, 0 when the task is not Ready) and selects the highest-priority Ready task.
- It sequences that task through Execute, run quantum and Finish on the shared 16-bit command bus, then rescans.
- It is the single driver of the command bus that all task blocks decode.

Parameters:
- N_TASKS, 8, number of task slots on the sorter/exe_flag buses (2..16).
- QUANTUM, 10000, run cycles granted per dispatch before preemption.
- ACK_TIMEOUT, 16, cycles to wait for an exe_flag edge before abort.
- AGE_STEP, 1024, waiting cycles per +1 effective-priority bonus (only with SCHED_AGING_EN).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST_N  input  1  synchronous reset, active-low.
- task_entry  input  N_TASKS*8  packed sorter entries; slot k = [8k+7:8k] = {id[3:0], prio[3:0]}; 8'h00 = not Ready.
- task_exe  input  N_TASKS  exe_flag from each slot.
- cmd_op  output  16  command bus = {4'h0, id[3:0], op[3:0], arg[3:0]}; 16'h0000 = no-op.
- running_valid  output  1  a task is dispatched (RUN state).
- running_id  output  4  id of the dispatched task.
- sched_err  output  1  sticky: an ack timeout occurred.

Behaviour:
- Reset (RST_N=0 at a posedge) clears all outputs to 0, sets state=SCAN and last_grant=N_TASKS-1, and clears counters. No Finish is issued for a task that was running when reset arrived.
- Opcodes: EXEC=4'b0111, FINISH=4'b1111, SETPRIO=4'b0101. arg=0 except for SETPRIO.
- cmd_op is registered. It is non-zero for exactly one cycle per command and 0 at all other times.
- Ready: a slot is Ready when its entry != 8'h00. Effective priority = prio[3:0], unsigned.
- SCAN:
  - Select the Ready slot with maximum effective priority.
  - Ties go round-robin: the first tied slot strictly after last_grant, wrapping from N_TASKS-1 to 0.
  - Selection is registered (sel_idx, sel_id); go to DISPATCH the next cycle.
  - If no slot is Ready, stay in SCAN with cmd_op=0.
- DISPATCH:
  - Drive cmd_op={0,sel_id,EXEC,0} for 1 cycle.
  - Record last_grant=sel_idx, clear ack_cnt, go to WAIT_ON.
- WAIT_ON:
  - If task_exe[sel_idx]=1: go to RUN, set running_valid=1 and running_id=sel_id, clear q_cnt.
  - If ack_cnt reaches ACK_TIMEOUT first: set sched_err=1 and go to SCAN.
- RUN:
  - q_cnt increments each cycle.
  - Go to FINISH when any of these holds: q_cnt==QUANTUM-1; the slot's entry becomes 8'h00 (task left Ready); task_exe[sel_idx] falls.
  - Both conditions in the same cycle: single FINISH.
- FINISH:
  - Drive cmd_op={0,sel_id,FINISH,0} for 1 cycle.
  - Clear running_valid, go to WAIT_OFF.
- WAIT_OFF:
  - When task_exe[sel_idx]=0, go to SCAN.
  - On ACK_TIMEOUT, set sched_err=1 and go to SCAN.
- Latency: Ready task with all other slots idle → EXEC on cmd_op 2 cycles later (SCAN register + DISPATCH).
- Changes to task_entry outside SCAN/RUN are ignored until the next SCAN.
- sched_err clears only on reset.

Optional Feature:
- Macro: SCHED_AGING_EN.
- When defined:
  - Each non-selected Ready slot has a 4-bit age counter that increments every AGE_STEP cycles spent waiting, saturating at 15.
  - Effective priority = min(prio+age, 15), 5-bit add then saturate.
  - A slot's age clears when it is dispatched or its entry goes to 0.
  - On dispatch, the scheduler additionally issues {0,id,SETPRIO,min(prio+age,15)} in the cycle after EXEC, so the task's own priority register tracks the boost.
- When not defined: no age logic or SETPRIO issue; effective priority = prio.

Decomposition:
- Shared package sched_pkg:
  - Opcode localparams (EXEC, FINISH, SETPRIO, NOP).
  - Task-state encodings 2'b00..2'b11.
  - Entry field widths (ID_W=4, PRIO_W=4).
  - Scheduler state encoding (SCAN, DISPATCH, WAIT_ON, RUN, FINISH, WAIT_OFF).
- Sub-module sched_pick:
  - Combinational max-priority plus round-robin tie-break over N_TASKS entries given last_grant.
  - Outputs found, idx, id.

Test Plan:
- Only slot 2 Ready with entry 8'h53 → cmd_op=16'h0570 two cycles after reset release; after task_exe[2] rises, running_id=5; after QUANTUM cycles, cmd_op=16'h05F0.
- Slots 1 and 4 Ready with prio 3 and 9 → slot 4 dispatched first; after its Finish ack, slot 1 dispatched.
- Slots 0, 3, 6 all prio 7, each running a full quantum → dispatch order 0, 3, 6, 0 (round-robin wrap).
- task_exe never rises after EXEC → sched_err=1 after ACK_TIMEOUT cycles; scheduler returns to SCAN; cmd_op=0 throughout the wait.
- Running task's entry drops to 8'h00 mid-quantum → FINISH issued the next cycle. Separately, RST_N=0 during RUN → cmd_op=0, running_valid=0, sched_err=0 next cycle, and no FINISH issued.
- With SCHED_AGING_EN and AGE_STEP=4: prio-2 slot waiting behind a prio-5 slot for 12 cycles → effective priority 5, then wins the tie-break via round-robin, and SETPRIO arg=5 follows its EXEC.
